// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and transmit FSM state encoding.
// Used by the header inserter and the receive-side header parser.
package eth_pkg;

    localparam int ETH_HDR_LEN = 14;

    localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;

    localparam int DEFAULT_MIN_PAYLOAD = 46;
    localparam int DEFAULT_MAX_PAYLOAD = 1500;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_PAD     = 3'd3,
        ST_GAP     = 3'd4
    } eth_state_t;

endpackage

// File: rtl/eth_header_inserter.sv
// Transmit framer: emits the 14-byte Ethernet header, streams the upstream payload,
// zero-pads short payloads and enforces an idle gap after every frame.
module eth_header_inserter
    import eth_pkg::*;
#(
    parameter int MIN_PAYLOAD = DEFAULT_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD = DEFAULT_MAX_PAYLOAD,
    parameter int GAP_CYCLES  = 12
) (
    input  logic        clock,
    input  logic        sclr_n,
    input  logic        start,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic        is_arp,
    input  logic [7:0]  payload_data,
    input  logic        payload_valid,
    input  logic        payload_last,
    output logic        payload_ready,
    output logic [7:0]  dataout,
    output logic        data_en,
    output logic        busy,
    output logic        frame_done,
    output logic        tx_error
);

    localparam logic [10:0] MIN_P = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_P = 11'(MAX_PAYLOAD);
    localparam logic [15:0] GAP_W = 16'(GAP_CYCLES);
    localparam logic [3:0]  HDR_LAST = 4'(ETH_HDR_LEN - 1);

    eth_state_t  state, state_nx;
    logic [3:0]  hcnt, hcnt_nx;
    logic [10:0] pcnt, pcnt_nx, pcnt_inc;
    logic [15:0] gcnt, gcnt_nx;
    logic [47:0] dst_q, dst_nx;
    logic [47:0] src_q, src_nx;
    logic        arp_q, arp_nx;
    logic [7:0]  dout_nx;
    logic        den_nx, done_nx, err_nx;
    logic        done_pend, done_pend_nx;
    logic        err_pend, err_pend_nx;

    // Header laid out as one 112-bit word, most significant byte goes out first.
    function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [47:0] dst,
                                            input logic [47:0] src, input logic arp);
        logic [111:0] hdr;
        hdr = {dst, src, (arp ? ETHERTYPE_ARP : ETHERTYPE_IP)};
        hdr = hdr << {idx, 3'b000};
        return hdr[111:104];
    endfunction

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nx      = state;
        hcnt_nx       = hcnt;
        pcnt_nx       = pcnt;
        gcnt_nx       = gcnt;
        dst_nx        = dst_q;
        src_nx        = src_q;
        arp_nx        = arp_q;
        dout_nx       = dataout;
        den_nx        = data_en;
        done_nx       = 1'b0;
        err_nx        = 1'b0;
        done_pend_nx  = done_pend;
        err_pend_nx   = err_pend;
        payload_ready = 1'b0;
        pcnt_inc      = pcnt + 11'd1;

        case (state)
            ST_IDLE: begin
                dout_nx = 8'h00;
                den_nx  = 1'b0;
                if (start) begin
                    dst_nx       = dst_mac;
                    src_nx       = src_mac;
                    arp_nx       = is_arp;
                    pcnt_nx      = 11'd0;
                    gcnt_nx      = 16'd0;
                    done_pend_nx = 1'b0;
                    err_pend_nx  = 1'b0;
                    // Byte 0 is loaded straight from the ports so it appears the next cycle.
                    dout_nx      = hdr_byte(4'd0, dst_mac, src_mac, is_arp);
                    den_nx       = 1'b1;
                    hcnt_nx      = 4'd1;
                    state_nx     = ST_HEADER;
                end
            end

            ST_HEADER: begin
                dout_nx = hdr_byte(hcnt, dst_q, src_q, arp_q);
                den_nx  = 1'b1;
                hcnt_nx = hcnt + 4'd1;
                if (hcnt == HDR_LAST) begin
                    state_nx = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                payload_ready = 1'b1;
                if (payload_valid) begin
                    dout_nx = payload_data;
                    den_nx  = 1'b1;
                    pcnt_nx = pcnt_inc;
                    if (payload_last) begin
                        if (pcnt_inc < MIN_P) begin
                            state_nx = ST_PAD;
                        end else begin
                            state_nx     = ST_GAP;
                            gcnt_nx      = 16'd0;
                            done_pend_nx = 1'b1;
                        end
                    end else if (pcnt_inc == MAX_P) begin
                        state_nx    = ST_GAP;
                        gcnt_nx     = 16'd0;
                        err_pend_nx = 1'b1;
                    end
                end else begin
                    // Underrun: cut the frame now; the gap count starts with this dead cycle.
                    dout_nx  = 8'h00;
                    den_nx   = 1'b0;
                    err_nx   = 1'b1;
                    gcnt_nx  = 16'd1;
                    state_nx = ST_GAP;
                end
            end

            ST_PAD: begin
                dout_nx = 8'h00;
                den_nx  = 1'b1;
                pcnt_nx = pcnt_inc;
                if (pcnt_inc >= MIN_P) begin
                    state_nx     = ST_GAP;
                    gcnt_nx      = 16'd0;
                    done_pend_nx = 1'b1;
                end
            end

            ST_GAP: begin
                // gcnt == 0 is the cycle still showing the final byte; pulses land after it.
                dout_nx = 8'h00;
                den_nx  = 1'b0;
                if (gcnt == 16'd0) begin
                    done_nx      = done_pend;
                    err_nx       = err_pend;
                    done_pend_nx = 1'b0;
                    err_pend_nx  = 1'b0;
                end
                if (gcnt >= GAP_W) begin
                    state_nx = ST_IDLE;
                end else begin
                    gcnt_nx = gcnt + 16'd1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                den_nx   = 1'b0;
                dout_nx  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            state      <= ST_IDLE;
            hcnt       <= 4'd0;
            pcnt       <= 11'd0;
            gcnt       <= 16'd0;
            dst_q      <= 48'd0;
            src_q      <= 48'd0;
            arp_q      <= 1'b0;
            dataout    <= 8'h00;
            data_en    <= 1'b0;
            frame_done <= 1'b0;
            tx_error   <= 1'b0;
            done_pend  <= 1'b0;
            err_pend   <= 1'b0;
        end else begin
            state      <= state_nx;
            hcnt       <= hcnt_nx;
            pcnt       <= pcnt_nx;
            gcnt       <= gcnt_nx;
            dst_q      <= dst_nx;
            src_q      <= src_nx;
            arp_q      <= arp_nx;
            dataout    <= dout_nx;
            data_en    <= den_nx;
            frame_done <= done_nx;
            tx_error   <= err_nx;
            done_pend  <= done_pend_nx;
            err_pend   <= err_pend_nx;
        end
    end

endmodule

// File: tb/tb_eth_header_inserter.sv
// Self-checking bench for eth_header_inserter: table-driven frames, a reset
// sequence and randomized frames checked against a byte-list reference model.
module tb_eth_header_inserter;
    import eth_pkg::*;

    localparam int MIN_P = 46;
    localparam int MAX_P = 1500;
    localparam int GAP   = 12;

    logic        clock = 1'b0;
    logic        sclr_n;
    logic        start;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic        is_arp;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        payload_last;
    logic        payload_ready;
    logic [7:0]  dataout;
    logic        data_en;
    logic        busy;
    logic        frame_done;
    logic        tx_error;

    eth_header_inserter #(
        .MIN_PAYLOAD(MIN_P),
        .MAX_PAYLOAD(MAX_P),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock        (clock),
        .sclr_n       (sclr_n),
        .start        (start),
        .dst_mac      (dst_mac),
        .src_mac      (src_mac),
        .is_arp       (is_arp),
        .payload_data (payload_data),
        .payload_valid(payload_valid),
        .payload_last (payload_last),
        .payload_ready(payload_ready),
        .dataout      (dataout),
        .data_en      (data_en),
        .busy         (busy),
        .frame_done   (frame_done),
        .tx_error     (tx_error)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- records and scoreboard ----------------
    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic        arp;
        int          len;
        int          stop_at;
        bit          has_last;
        bit          rnd;
        bit          poke;
        int          exp_len;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t       vecs[9];
    logic [7:0] pl[0:MAX_P+15];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int start_cyc, first_cyc, last_cyc, fall_cyc, prev_last;
    int rises, fd_cnt, fd_cyc, te_cnt, te_cyc, rdy_cnt, rdy_first;
    int exp_acc;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] d, input logic [47:0] s, input logic a,
                                input int len, input int stop, input bit last, input bit rnd,
                                input bit poke, input int el, input bit ed, input bit ee);
        vec_t v;
        v.dst = d; v.src = s; v.arp = a; v.len = len; v.stop_at = stop;
        v.has_last = last; v.rnd = rnd; v.poke = poke;
        v.exp_len = el; v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    // Reference model: the frame is a plain list of bytes built from the framing rules.
    task automatic build_expected(input vec_t v);
        logic [15:0] etype;
        bit          complete;
        exp_q.delete();
        for (int i = 5; i >= 0; i--) exp_q.push_back(v.dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(v.src[i*8 +: 8]);
        etype = v.arp ? 16'h0806 : 16'h0800;
        exp_q.push_back(etype[15:8]);
        exp_q.push_back(etype[7:0]);
        if (v.stop_at >= 0)     exp_acc = v.stop_at;
        else if (v.len > MAX_P) exp_acc = MAX_P;
        else                    exp_acc = v.len;
        for (int i = 0; i < exp_acc; i++) exp_q.push_back(pl[i]);
        complete = (v.stop_at < 0) && v.has_last && (v.len <= MAX_P);
        if (complete) begin
            for (int i = exp_acc; i < MIN_P; i++) exp_q.push_back(8'h00);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_payload(input vec_t v);
        int i;
        bit seen;
        bit poked;
        i = 0; seen = 0; poked = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (seen && !payload_ready) break;
            if (payload_ready) seen = 1'b1;
            if (v.poke && seen && i == 5 && !poked) begin
                start   = 1'b1;
                dst_mac = ~v.dst;
                is_arp  = ~v.arp;
                poked   = 1'b1;
            end
            payload_valid = (i != v.stop_at) && (i < v.len);
            payload_data  = pl[i];
            payload_last  = v.has_last && (i == v.len - 1);
            if (payload_ready && payload_valid) i++;
        end
        start         = 1'b0;
        payload_valid = 1'b0;
        payload_last  = 1'b0;
    endtask

    task automatic monitor_frame(input string tag);
        bit prev_en;
        bit seen_busy;
        bit ended;
        prev_en = 0; seen_busy = 0; ended = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clock);
            if (data_en) begin
                got_q.push_back(dataout);
                if (!prev_en) begin
                    rises++;
                    if (rises == 1) first_cyc = cyc;
                end
                last_cyc = cyc;
            end
            prev_en = data_en;
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            if (tx_error)   begin te_cnt++; te_cyc = cyc; end
            if (payload_ready) begin
                if (rdy_cnt == 0) rdy_first = cyc;
                rdy_cnt++;
            end
            if (busy) seen_busy = 1'b1;
            else if (seen_busy) begin
                fall_cyc = cyc;
                ended    = 1'b1;
                break;
            end
        end
        check({tag, " busy_end_in_budget"}, int'(ended), 1);
    endtask

    // Caller must be at a negedge; start is raised immediately.
    task automatic run_frame(input vec_t v, input string tag);
        int bad_idx;
        int ulen;
        for (int i = 0; i < v.len && i <= MAX_P + 15; i++)
            pl[i] = v.rnd ? 8'($urandom) : 8'(i + 1);
        build_expected(v);
        got_q.delete();
        rises = 0; fd_cnt = 0; te_cnt = 0; rdy_cnt = 0;
        first_cyc = -1; last_cyc = -1; fd_cyc = -1; te_cyc = -1; rdy_first = -1; fall_cyc = -1;

        dst_mac = v.dst; src_mac = v.src; is_arp = v.arp;
        payload_valid = 1'b0; payload_last = 1'b0;
        start = 1'b1;
        start_cyc = cyc;
        fork
            drive_payload(v);
            monitor_frame(tag);
        join

        check({tag, " length"}, got_q.size(), v.exp_len);
        bad_idx = -1;
        ulen = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < ulen; i++) begin
            if (bad_idx < 0 && got_q[i] !== exp_q[i]) bad_idx = i;
        end
        n_checks++;
        if (bad_idx >= 0) begin
            n_errors++;
            $display("FAIL %s bytes: index %0d got %02h expected %02h",
                     tag, bad_idx, got_q[bad_idx], exp_q[bad_idx]);
        end
        check({tag, " contiguous"}, rises, 1);
        check({tag, " first_byte_cycle"}, first_cyc, start_cyc + 1);
        check({tag, " last_byte_cycle"}, last_cyc, start_cyc + v.exp_len);
        check({tag, " frame_done_count"}, fd_cnt, int'(v.exp_done));
        check({tag, " tx_error_count"}, te_cnt, int'(v.exp_err));
        if (v.exp_done) check({tag, " frame_done_cycle"}, fd_cyc, last_cyc + 1);
        if (v.exp_err)  check({tag, " tx_error_cycle"}, te_cyc, last_cyc + 1);
        check({tag, " busy_fall_cycle"}, fall_cyc, last_cyc + GAP + 1);
        check({tag, " ready_first_cycle"}, rdy_first, start_cyc + 14);
        check({tag, " ready_cycles"}, rdy_cnt, exp_acc + ((v.stop_at >= 0) ? 1 : 0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t rv;
        int   len;
        int   stop;

        sclr_n = 1'b0; start = 1'b0; dst_mac = '0; src_mac = '0; is_arp = 1'b0;
        payload_data = 8'h00; payload_valid = 1'b0; payload_last = 1'b0;
        prev_last = -1000;

        vecs[0] = mk(48'h001122334455, 48'hAABBCCDDEEFF, 1'b0,   20, -1, 1, 0, 0,   60, 1, 0);
        vecs[1] = mk(48'h0A0B0C0D0E0F, 48'h102030405060, 1'b1,   46, -1, 1, 1, 0,   60, 1, 0);
        vecs[2] = mk(48'h001122334455, 48'hAABBCCDDEEFF, 1'b0,   20, 10, 1, 0, 0,   24, 0, 1);
        vecs[3] = mk(48'hFFFFFFFFFFFF, 48'h020000000001, 1'b0,   47, -1, 1, 1, 1,   61, 1, 0);
        vecs[4] = mk(48'h123456789ABC, 48'hDEF012345678, 1'b1,    1, -1, 1, 1, 0,   60, 1, 0);
        vecs[5] = mk(48'h0000000000AA, 48'h0000000000BB, 1'b0,   30,  0, 1, 0, 0,   14, 0, 1);
        vecs[6] = mk(48'h111111111111, 48'h222222222222, 1'b0, 1501, -1, 0, 1, 0, 1514, 0, 1);
        vecs[7] = mk(48'h333333333333, 48'h444444444444, 1'b1, 1500, -1, 1, 1, 0, 1514, 1, 0);
        vecs[8] = mk(48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 1'b0,   45, -1, 1, 1, 0,   60, 1, 0);

        repeat (3) @(negedge clock);
        check("reset_outputs",
              int'({dataout, data_en, payload_ready, busy, frame_done, tx_error}), 0);
        sclr_n = 1'b1;
        @(negedge clock);
        check("idle_outputs",
              int'({dataout, data_en, payload_ready, busy, frame_done, tx_error}), 0);

        // Frames run back to back: each start is raised the cycle busy is seen low.
        for (int k = 0; k < 9; k++) begin
            run_frame(vecs[k], $sformatf("vec%0d", k));
            if (k > 0) check($sformatf("vec%0d spacing_ge_gap", k),
                             int'((first_cyc - prev_last) >= GAP), 1);
            prev_last = last_cyc;
        end

        // Reset while header byte 5 is on the output.
        @(negedge clock);
        dst_mac = 48'h665544332211; src_mac = 48'h0102030405AB; is_arp = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("rst_mid byte5_value", int'(dataout), 8'h11);
        check("rst_mid byte5_en", int'(data_en), 1);
        sclr_n = 1'b0;
        @(negedge clock);
        check("rst_mid outputs_zero",
              int'({dataout, data_en, payload_ready, busy, frame_done, tx_error}), 0);
        sclr_n = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_mid no_restart", int'({data_en, busy}), 0);
        run_frame(vecs[0], "after_reset");
        prev_last = last_cyc;

        // Randomized frames against the reference model.
        for (int r = 0; r < 20; r++) begin
            len  = int'($urandom_range(1, 80));
            stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            rv   = mk({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF, {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF,
                      1'($urandom_range(0, 1)), len, stop, 1, 1, 0,
                      (stop >= 0) ? 14 + stop : 14 + ((len < MIN_P) ? MIN_P : len),
                      stop < 0, stop >= 0);
            run_frame(rv, $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d spacing_ge_gap", r), int'((first_cyc - prev_last) >= GAP), 1);
            prev_last = last_cyc;
        end

        repeat (4) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
